// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// the instruction word layout.
package instr_sequencer_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_ADDST = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_HALT
    } state_e;

    localparam int unsigned OPC_LSB  = 29;
    localparam int unsigned RD_LSB   = 25;
    localparam int unsigned RA_LSB   = 21;
    localparam int unsigned RB_LSB   = 17;
    localparam int unsigned ADDR_LSB = 9;
    localparam int unsigned WB_BIT   = 8;
    localparam int unsigned HALT_BIT = 7;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] addr;
        logic       wb_en;
        logic       halt;
        logic [6:0] rsvd;
    } instr_t;

endpackage

// File: rtl/instr_sequencer_regfile.sv
// 16x32 operand register file: two asynchronous read ports, one write port
// where ALU write-back wins over an external write.
module seq_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  ra_i,
    input  logic [3:0]  rb_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        ext_we_i,
    input  logic [3:0]  ext_addr_i,
    input  logic [31:0] ext_data_i
);

    logic [31:0] mem_q [16];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_we_i) begin
            mem_q[wb_addr_i] <= wb_data_i;
        end else if (ext_we_i) begin
            mem_q[ext_addr_i] <= ext_data_i;
        end
    end

    assign a_o = mem_q[ra_i];
    assign b_o = mem_q[rb_i];

endmodule

// File: rtl/instr_sequencer.sv
// Issue stage: fetches from a loadable instruction memory, reads operands and
// hands opcode/A/B/addr to the ALU stage, with optional result write-back.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned IADDR_W    = $clog2(IMEM_DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_en_i,
    input  logic [IADDR_W-1:0] load_addr_i,
    input  logic [31:0]        load_data_i,
    input  logic               rf_we_i,
    input  logic [3:0]         rf_waddr_i,
    input  logic [31:0]        rf_wdata_i,
    input  logic               start_i,
    output logic [2:0]         opcode_o,
    output logic [31:0]        a_o,
    output logic [31:0]        b_o,
    output logic [7:0]         addr_o,
    output logic               issue_valid_o,
    input  logic               issue_ready_i,
    input  logic [31:0]        result_in_i,
    input  logic               result_valid_i,
    output logic [IADDR_W-1:0] pc_o,
    output logic               busy_o,
    output logic               halted_o
);

    logic [31:0]        imem [IMEM_DEPTH];
    state_e             state_q, state_d;
    logic [IADDR_W-1:0] pc_q, pc_d;
    logic [2:0]         opcode_q;
    logic [31:0]        a_q, b_q;
    logic [7:0]         addr_q;
    logic [3:0]         rd_q;
    logic               wb_q, halt_q;
    instr_t             fetch_word;
    logic [31:0]        rf_a, rf_b;
    logic               idle_like, wb_fire;
    logic [6:0]         unused_rsvd;

    assign idle_like   = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign wb_fire     = (state_q == ST_WAIT_RES) && result_valid_i;
    assign fetch_word  = instr_t'(imem[pc_q]);
    assign unused_rsvd = fetch_word.rsvd;

    // No reset on imem: contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (load_en_i && idle_like) begin
            imem[load_addr_i] <= load_data_i;
        end
    end

    seq_regfile u_regfile (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ra_i       (fetch_word.ra),
        .rb_i       (fetch_word.rb),
        .a_o        (rf_a),
        .b_o        (rf_b),
        .wb_we_i    (wb_fire),
        .wb_addr_i  (rd_q),
        .wb_data_i  (result_in_i),
        .ext_we_i   (rf_we_i && idle_like),
        .ext_addr_i (rf_waddr_i),
        .ext_data_i (rf_wdata_i)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (issue_ready_i) begin
                    if (wb_q) begin
                        state_d = ST_WAIT_RES;
                    end else if (halt_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + IADDR_W'(1);
                    end
                end
            end
            ST_WAIT_RES: begin
                if (result_valid_i) begin
                    if (halt_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + IADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue fields are captured at the end of FETCH and held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == ST_FETCH) begin
                opcode_q <= fetch_word.opcode;
                a_q      <= rf_a;
                b_q      <= rf_b;
                addr_q   <= fetch_word.addr;
                rd_q     <= fetch_word.rd;
                wb_q     <= fetch_word.wb_en;
                halt_q   <= fetch_word.halt;
            end
        end
    end

    assign opcode_o      = opcode_q;
    assign a_o           = a_q;
    assign b_o           = b_q;
    assign addr_o        = addr_q;
    assign pc_o          = pc_q;
    assign issue_valid_o = (state_q == ST_ISSUE);
    assign busy_o        = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                           (state_q == ST_WAIT_RES);
    assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven program plus
// hand-written sequences, expected issues held in a scoreboard queue.
module tb_instr_sequencer;

    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned IADDR_W    = 6;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               load_en_i = 1'b0;
    logic [IADDR_W-1:0] load_addr_i = '0;
    logic [31:0]        load_data_i = '0;
    logic               rf_we_i = 1'b0;
    logic [3:0]         rf_waddr_i = '0;
    logic [31:0]        rf_wdata_i = '0;
    logic               start_i = 1'b0;
    logic [2:0]         opcode_o;
    logic [31:0]        a_o, b_o;
    logic [7:0]         addr_o;
    logic               issue_valid_o;
    logic               issue_ready_i = 1'b0;
    logic [31:0]        result_in_i = '0;
    logic               result_valid_i = 1'b0;
    logic [IADDR_W-1:0] pc_o;
    logic               busy_o, halted_o;

    instr_sequencer #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IADDR_W    (IADDR_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .load_en_i      (load_en_i),
        .load_addr_i    (load_addr_i),
        .load_data_i    (load_data_i),
        .rf_we_i        (rf_we_i),
        .rf_waddr_i     (rf_waddr_i),
        .rf_wdata_i     (rf_wdata_i),
        .start_i        (start_i),
        .opcode_o       (opcode_o),
        .a_o            (a_o),
        .b_o            (b_o),
        .addr_o         (addr_o),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .result_in_i    (result_in_i),
        .result_valid_i (result_valid_i),
        .pc_o           (pc_o),
        .busy_o         (busy_o),
        .halted_o       (halted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rd, ra, rb;
        logic [7:0]  addr;
        logic        wb, halt;
        logic [31:0] ea, eb;
    } row_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [7:0]  addr;
        logic [5:0]  pc;
        logic        wb;
    } exp_t;

    row_t rows [5];
    exp_t sb [$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [7:0] addr, input logic wb,
                                        input logic halt);
        return {op, rd, ra, rb, addr, wb, halt, 7'h55};
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a + b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] rfv(input int k);
        return k * 32'h0101_0101 + 32'd1;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_imem(input int addr, input logic [31:0] data);
        load_en_i = 1'b1;
        load_addr_i = addr[IADDR_W-1:0];
        load_data_i = data;
        step();
        load_en_i = 1'b0;
    endtask

    task automatic write_rf(input int idx, input logic [31:0] val);
        rf_we_i = 1'b1;
        rf_waddr_i = idx[3:0];
        rf_wdata_i = val;
        step();
        rf_we_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic push_row(input row_t r, input int pc);
        exp_t e;
        e.op = r.op; e.a = r.ea; e.b = r.eb; e.addr = r.addr; e.pc = pc[5:0]; e.wb = r.wb;
        sb.push_back(e);
    endtask

    // Acts as the ALU stage: accepts issues (optionally stalling), returns
    // write-back results one cycle after accept and checks against the scoreboard.
    task automatic run_prog(input int budget, input int stall, input int max_issues,
                            input bit noise, output int cycles);
        int cyc = 0;
        int nissue = 0;
        int stall_cnt = 0;
        int wb_phase = 0;
        logic [31:0] res = '0;
        exp_t e;
        issue_ready_i = (stall == 0);
        forever begin
            @(negedge clk_i);
            cyc++;
            if (cyc > budget) begin
                check("run within cycle budget", cyc, budget);
                break;
            end
            if (wb_phase == 2) begin
                check("wait_res issue_valid", issue_valid_o, 0);
                check("wait_res busy", busy_o, 1);
                wb_phase = 0;
            end
            if (halted_o) break;
            if (issue_valid_o) begin
                if (sb.size() == 0) begin
                    check("issue with empty scoreboard", sb.size(), 1);
                    break;
                end
                e = sb[0];
                check("opcode", opcode_o, e.op);
                check("A", a_o, e.a);
                check("B", b_o, e.b);
                check("addr", addr_o, e.addr);
                check("pc at issue", pc_o, e.pc);
                if (issue_ready_i) begin
                    void'(sb.pop_front());
                    nissue++;
                    stall_cnt = 0;
                    if (e.wb) begin
                        wb_phase = 1;
                        res = alu(e.op, e.a, e.b);
                    end
                end else begin
                    stall_cnt++;
                end
            end else if (stall_cnt != 0) begin
                check("issue_valid held under stall", issue_valid_o, 1);
                stall_cnt = 0;
            end
            if (max_issues != 0 && nissue >= max_issues) break;
            step();
            issue_ready_i = (stall_cnt >= stall);
            result_valid_i = 1'b1;
            if (wb_phase == 1) begin
                result_in_i = res;
                wb_phase = 2;
            end else begin
                result_in_i = 32'hBAD0_0000 | cyc;
            end
            if (noise && sb.size() != 0) begin
                load_en_i = 1'b1; load_addr_i = cyc[5:0]; load_data_i = 32'hFFFF_FFFF;
                rf_we_i = 1'b1; rf_waddr_i = cyc[3:0]; rf_wdata_i = 32'hDEAD_0000 | cyc;
                start_i = 1'b1;
            end else begin
                load_en_i = 1'b0; rf_we_i = 1'b0; start_i = 1'b0;
            end
        end
        result_valid_i = 1'b0;
        load_en_i = 1'b0; rf_we_i = 1'b0; start_i = 1'b0;
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        bit got;
        exp_t e;

        rows[0] = '{3'b000, 4'd3, 4'd1, 4'd2, 8'h05, 1'b1, 1'b0, 32'd10, 32'd20};
        rows[1] = '{3'b001, 4'd4, 4'd3, 4'd5, 8'h09, 1'b1, 1'b0, 32'd30, 32'd7};
        rows[2] = '{3'b010, 4'd0, 4'd4, 4'd1, 8'hFF, 1'b0, 1'b0, 32'd23, 32'd10};
        rows[3] = '{3'b011, 4'd6, 4'd4, 4'd2, 8'h80, 1'b1, 1'b0, 32'd23, 32'd20};
        rows[4] = '{3'b100, 4'd0, 4'd6, 4'd3, 8'h01, 1'b0, 1'b1, 32'd23, 32'd30};

        // Reset values
        step();
        step();
        check("reset opcode", opcode_o, 0);
        check("reset A", a_o, 0);
        check("reset B", b_o, 0);
        check("reset addr", addr_o, 0);
        check("reset issue_valid", issue_valid_o, 0);
        check("reset pc", pc_o, 0);
        check("reset busy", busy_o, 0);
        check("reset halted", halted_o, 0);
        rst_ni = 1'b1;
        step();

        // Table program with write-back chain; busy-time loads/writes/start are noise
        write_rf(1, 32'd10);
        write_rf(2, 32'd20);
        write_rf(5, 32'd7);
        for (int i = 0; i < 5; i++) begin
            load_imem(i, enc(rows[i].op, rows[i].rd, rows[i].ra, rows[i].rb, rows[i].addr,
                             rows[i].wb, rows[i].halt));
            push_row(rows[i], i);
        end
        pulse_start();
        run_prog(100, 0, 0, 1'b1, cyc);
        check("program cycles", cyc, 14);
        check("halted after program", halted_o, 1);
        check("pc held at halt", pc_o, 4);
        check("busy in halt", busy_o, 0);
        check("issue_valid in halt", issue_valid_o, 0);
        check("opcode holds last issue", opcode_o, 3'b100);
        check("A holds last issue", a_o, 32'd23);
        check("scoreboard drained", sb.size(), 0);

        // Restart from HALT with 4-cycle backpressure on every issue
        for (int i = 0; i < 5; i++) push_row(rows[i], i);
        pulse_start();
        run_prog(200, 4, 0, 1'b0, cyc);
        check("stalled program cycles", cyc, 34);
        check("halted after stalled run", halted_o, 1);
        check("pc after stalled run", pc_o, 4);
        check("scoreboard drained (stall)", sb.size(), 0);

        // New program loaded in HALT: full imem, no halt, pc wraps to 0
        for (int k = 0; k < 16; k++) write_rf(k, rfv(k));
        for (int i = 0; i < 64; i++) begin
            load_imem(i, enc(3'b011, 4'd0, 4'(i % 16), 4'(15 - i % 16), 8'(i), 1'b0, 1'b0));
        end
        for (int i = 0; i < 66; i++) begin
            e.op = 3'b011; e.a = rfv(i % 16); e.b = rfv(15 - i % 16);
            e.addr = 8'(i % 64); e.pc = 6'(i % 64); e.wb = 1'b0;
            sb.push_back(e);
        end
        pulse_start();
        run_prog(400, 0, 66, 1'b0, cyc);
        check("scoreboard drained (wrap)", sb.size(), 0);

        // Asynchronous reset while an issue is pending
        step();
        issue_ready_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            got = issue_valid_o;
        end
        check("issue pending before reset", got, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid-issue reset opcode", opcode_o, 0);
        check("mid-issue reset A", a_o, 0);
        check("mid-issue reset B", b_o, 0);
        check("mid-issue reset addr", addr_o, 0);
        check("mid-issue reset issue_valid", issue_valid_o, 0);
        check("mid-issue reset pc", pc_o, 0);
        check("mid-issue reset busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Start together with a load to imem[0]; dependency on write-back; rf[3] cleared
        write_rf(1, 32'd10);
        write_rf(2, 32'd15);
        load_imem(1, enc(3'b001, 4'd0, 4'd4, 4'd3, 8'h33, 1'b0, 1'b1));
        load_en_i = 1'b1;
        load_addr_i = '0;
        load_data_i = enc(3'b000, 4'd4, 4'd1, 4'd2, 8'h5A, 1'b1, 1'b0);
        start_i = 1'b1;
        step();
        load_en_i = 1'b0;
        start_i = 1'b0;
        e.op = 3'b000; e.a = 32'd10; e.b = 32'd15; e.addr = 8'h5A; e.pc = 6'd0; e.wb = 1'b1;
        sb.push_back(e);
        e.op = 3'b001; e.a = 32'd25; e.b = 32'd0; e.addr = 8'h33; e.pc = 6'd1; e.wb = 1'b0;
        sb.push_back(e);
        run_prog(50, 0, 0, 1'b0, cyc);
        check("halted after dependency run", halted_o, 1);
        check("pc after dependency run", pc_o, 1);
        check("scoreboard drained (dependency)", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream issue stage for the ALU/RAM top block.
- Holds a loadable instruction memory, a 16x32 operand register file and a program counter.
- Fetches and decodes each instruction, then issues opcode/A/B/addr to the ALU stage over a valid/ready handshake.
- Optionally writes the ALU result back into the register file before fetching the next instruction.

Parameters:
IMEM_DEPTH, 64, instruction memory words (power of two)
IADDR_W, 6, log2(IMEM_DEPTH); width of pc and load_addr

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_en  in  1  write load_data into imem[load_addr]; honoured only in IDLE/HALT
load_addr  in  IADDR_W  imem write address
load_data  in  32  instruction word
rf_we  in  1  external register-file write; honoured only in IDLE/HALT
rf_waddr  in  4  register index
rf_wdata  in  32  register data
start  in  1  begin execution at pc=0 (IDLE or HALT only)
opcode  out  3  to ALU stage
A  out  32  rf[ra]
B  out  32  rf[rb]
addr  out  8  RAM address field
issue_valid  out  1  opcode/A/B/addr valid this cycle
issue_ready  in  1  ALU stage accepts issue
result_in  in  32  ALU result (alu_out)
result_valid  in  1  result_in valid for write-back
pc  out  IADDR_W  current program counter
busy  out  1  high in FETCH/ISSUE/WAIT_RES
halted  out  1  high in HALT

Behaviour:
- Instruction format: [31:29] opcode, [28:25] rd, [24:21] ra, [20:17] rb, [16:9] addr, [8] wb_en, [7] halt, [6:0] reserved (ignored).
- Reset (reset=0, async): state=IDLE; pc, opcode, A, B, addr, issue_valid, busy and halted all 0; rf cleared to 0. imem contents are not reset.
- IDLE: load/rf_we writes accepted. On start, pc<=0 and go to FETCH.
- FETCH (1 cycle): ir<=imem[pc] (synchronous read), then go to ISSUE.
- ISSUE: issue_valid=1. opcode/A/B/addr are registered from ir and rf on entry and held stable while issue_ready=0. On issue_valid&&issue_ready:
  - if wb_en, go to WAIT_RES;
  - else pc<=pc+1, then go to FETCH, or to HALT if the halt bit is set.
- WAIT_RES: issue_valid=0. On result_valid, rf[rd]<=result_in and pc<=pc+1, then go to FETCH, or to HALT if halt is set. result_valid is ignored in every other state.
- HALT: halted=1; load/rf_we accepted. start restarts at pc=0 via FETCH. pc holds its value; it is not incremented on halt.
- pc wraps from IMEM_DEPTH-1 to 0 (modulo IADDR_W).
- Operand read-after-write: a write-back completes before the next FETCH, so the next issue always sees the updated rf. No bypass is needed.
- Outside ISSUE, opcode/A/B/addr hold their last issued values.
- start while busy: ignored. load_en/rf_we while busy: ignored; imem/rf unchanged.
- Simultaneous start and load in IDLE: the load is performed and start is taken in the same cycle. FETCH reads the new word if load_addr==0 (write-first).
- Reset asserted mid-operation: immediate return to IDLE and outputs cleared. An in-flight issue is dropped.
- Per instruction without write-back: 2 cycles (FETCH+ISSUE) when issue_ready is held high. With write-back: +1 cycle minimum.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_ADDST=100;
  - state encoding ST_IDLE/ST_FETCH/ST_ISSUE/ST_WAIT_RES/ST_HALT;
  - instruction field bit positions.
- One sub-module: seq_regfile (16x32, two async read ports, one write port with internal write-back priority over external write).

Test Plan:
- Reset mid-ISSUE (issue_ready=0) -> all outputs 0 and state IDLE within the same cycle; rf[3] reads 0 afterwards.
- Load rf[1]=10, rf[2]=20; imem[0]={000,rd=3,ra=1,rb=2,addr=5,wb=1,halt=0}, imem[1]={...halt=1}; start, issue_ready=1, result_in=30 with result_valid 1 cycle after issue -> first issue shows opcode=000, A=10, B=20, addr=5; rf[3]=30; halted=1; pc=1.
- Backpressure: issue_ready low for 4 cycles -> issue_valid stays 1 with opcode/A/B/addr unchanged; pc unchanged until accept.
- Write-back dependency: instr0 rd=4 (result 25), instr1 ra=4 -> instr1 issues A=25.
- Wrap: IMEM_DEPTH=64, no halt bits in 0..63, no wb -> after instr at 63, pc=0 and fetch repeats imem[0].
- load_en/rf_we/start during busy -> ignored: imem/rf unchanged and execution sequence unaffected; load after HALT then start -> new program runs from pc=0.
